// File: rtl/rand_arbiter_pkg.sv
// Shared types and helpers for the round-robin random-number arbiter:
// FSM state encoding, generator feedback step and bound-to-mask smear.
package rand_arbiter_pkg;

  localparam int LEN_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_STEP  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Shift left, feed back the XOR of the two top bits of a len-bit register.
  function automatic logic [LEN_MAX-1:0] lfsr_step(input logic [LEN_MAX-1:0] g,
                                                   input int len);
    logic [LEN_MAX-1:0] taps;
    logic [LEN_MAX-1:0] keep;
    logic               fb;
    taps = LEN_MAX'(3) << (len - 2);
    fb   = ^(g & taps);
    keep = (len >= LEN_MAX) ? '1 : ((LEN_MAX'(1) << len) - LEN_MAX'(1));
    return ((g << 1) | LEN_MAX'(fb)) & keep;
  endfunction

  // All ones at and below the MSB of (b-1); b==0 selects the full range.
  function automatic logic [LEN_MAX-1:0] mask_from_bound(input logic [LEN_MAX-1:0] b);
    logic [LEN_MAX-1:0] x;
    if (b == '0) return '1;
    x = b - LEN_MAX'(1);
    x = x | (x >> 1);
    x = x | (x >> 2);
    x = x | (x >> 4);
    x = x | (x >> 8);
    x = x | (x >> 16);
    return x;
  endfunction

endpackage

// File: rtl/rand_arbiter_lfsr_core.sv
// Shift-register pseudo-random generator shared by all requesters.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr_core
  import rand_arbiter_pkg::*;
#(
  parameter int NUM_LEN = 10,
  parameter int SEED    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en_i,
  output logic [NUM_LEN-1:0] value_o
);

  localparam logic [NUM_LEN-1:0] SEED_TRUNC = NUM_LEN'(SEED);
  localparam logic [NUM_LEN-1:0] SEED_EFF   = (SEED_TRUNC == '0) ? NUM_LEN'(1) : SEED_TRUNC;

  logic [NUM_LEN-1:0] g_q;
  logic [NUM_LEN-1:0] g_d;
  logic [LEN_MAX-1:0] step_full;
  logic               unused_step;

  assign step_full   = lfsr_step(LEN_MAX'(g_q), NUM_LEN);
  assign g_d         = step_full[NUM_LEN-1:0];
  assign unused_step = ^step_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= SEED_EFF;
    end else if (step_en_i) begin
      g_q <= g_d;
    end
  end

  assign value_o = g_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out bounded pseudo-random values from one
// shared generator, using rejection sampling with a subtract fallback.
//
// state | meaning
// IDLE  | waiting; picks next requester at/after the pointer
// GRANT | builds the range mask from the latched bound
// STEP  | advances the generator, counts a try
// CHECK | accepts, retries, or falls back to sample-bound
// RESP  | one-cycle ack to the winner, pointer moves past it
module rand_arbiter
  import rand_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LEN   = 10,
  parameter int SEED      = 1,
  parameter int MAX_TRIES = 8,
  parameter int FREE_RUN  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*NUM_LEN-1:0] bound,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_LEN-1:0]         rand_out,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d, pick_idx;
  logic [NUM_LEN-1:0] bound_q, bound_d, mask_q, mask_d, rand_q, rand_d;
  logic [NUM_LEN-1:0] pick_bound, mask_calc, gen, sample;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [LEN_MAX-1:0] mask_full;
  logic               unused_mask;
  logic               pick_found, accept, give_up, gen_step;

  lfsr_core #(.NUM_LEN(NUM_LEN), .SEED(SEED)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .step_en_i (gen_step),
    .value_o   (gen)
  );

  // Priority scan starting at the pointer and wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = int'(ptr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!pick_found && ((req >> c) & NUM_REQ'(1)) != '0) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(c);
      end
    end
  end

  always_comb begin
    pick_bound = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_bound = bound[i*NUM_LEN +: NUM_LEN];
    end
  end

  assign mask_full   = mask_from_bound(LEN_MAX'(bound_q));
  assign mask_calc   = mask_full[NUM_LEN-1:0];
  assign unused_mask = ^mask_full;
  assign sample      = gen & mask_q;
  assign accept      = (bound_q == '0) || (sample < bound_q);
  assign give_up     = (tries_q >= TRY_W'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_STEP;
      ST_STEP:  state_d = ST_CHECK;
      ST_CHECK: state_d = (accept || give_up) ? ST_RESP : ST_STEP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    gen_step = (state_q == ST_STEP) || ((FREE_RUN != 0) && (state_q == ST_IDLE));
    ack      = '0;
    if (state_q == ST_RESP) ack = NUM_REQ'(1) << win_q;
  end

  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    rand_d  = rand_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          bound_d = pick_bound;
        end
      end
      ST_GRANT: begin
        mask_d  = mask_calc;
        tries_d = '0;
      end
      ST_STEP:  tries_d = tries_q + TRY_W'(1);
      ST_CHECK: begin
        // mask < 2*bound, so one subtraction always lands in range.
        if (accept)       rand_d = sample;
        else if (give_up) rand_d = sample - bound_q;
      end
      ST_RESP:  ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      bound_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rand_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      bound_q <= bound_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rand_q  <= rand_d;
    end
  end

  assign rand_out = rand_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter: latency, values, fairness, reset abort
// and range of returned values, across three seed/retry configurations.
module tb_rand_arbiter;
  import rand_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NL = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_a, req_b, req_c;
  logic [NR*NL-1:0] bound_a, bound_b, bound_c;
  logic [NR-1:0]    ack_a, ack_b, ack_c;
  logic [NL-1:0]    rand_a, rand_b, rand_c;
  logic             busy_a, busy_b, busy_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rand_arbiter #(.NUM_REQ(NR), .NUM_LEN(NL), .SEED(1), .MAX_TRIES(8), .FREE_RUN(0)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .bound(bound_a),
    .ack(ack_a), .rand_out(rand_a), .busy(busy_a));

  rand_arbiter #(.NUM_REQ(NR), .NUM_LEN(NL), .SEED(3), .MAX_TRIES(8), .FREE_RUN(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .bound(bound_b),
    .ack(ack_b), .rand_out(rand_b), .busy(busy_b));

  rand_arbiter #(.NUM_REQ(NR), .NUM_LEN(NL), .SEED(3), .MAX_TRIES(1), .FREE_RUN(0)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .bound(bound_c),
    .ack(ack_c), .rand_out(rand_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR-1:0] get_ack(input int w);
    case (w)
      0:       return ack_a;
      1:       return ack_b;
      default: return ack_c;
    endcase
  endfunction

  function automatic logic [NL-1:0] get_rand(input int w);
    case (w)
      0:       return rand_a;
      1:       return rand_b;
      default: return rand_c;
    endcase
  endfunction

  task automatic set_req(input int w, input int idx, input logic v);
    case (w)
      0:       req_a[idx] = v;
      1:       req_b[idx] = v;
      default: req_c[idx] = v;
    endcase
  endtask

  task automatic set_bound(input int w, input int idx, input logic [NL-1:0] b);
    case (w)
      0:       bound_a[idx*NL +: NL] = b;
      1:       bound_b[idx*NL +: NL] = b;
      default: bound_c[idx*NL +: NL] = b;
    endcase
  endtask

  // One request; latency counts rising edges, the sampling edge being 1.
  // exp_lat==0 skips the latency check; use_val==0 checks only the range.
  task automatic txn(input int w, input int idx, input logic [NL-1:0] bnd,
                     input int exp_lat, input logic [NL-1:0] exp_val,
                     input bit use_val, input string tag);
    int            lat;
    bit            seen;
    logic [NL-1:0] got;
    set_bound(w, idx, bnd);
    set_req(w, idx, 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (get_ack(w) != '0) seen = 1'b1;
    end
    chk({tag, ".ack_seen"}, 32'(seen), 32'd1);
    got = get_rand(w);
    if (seen) begin
      chk({tag, ".ack_vec"}, 32'(get_ack(w)), 32'(1) << idx);
      if (exp_lat > 0) chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      if (use_val)     chk({tag, ".value"}, 32'(got), 32'(exp_val));
      else             chk({tag, ".in_range"}, 32'(got < bnd), 32'd1);
    end
    set_req(w, idx, 1'b0);
    tick();
    chk({tag, ".ack_single"}, 32'(get_ack(w)), 32'd0);
    chk({tag, ".held"}, 32'(get_rand(w)), 32'(got));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the next ack on the default instance and compare it.
  task automatic expect_ack(input logic [NR-1:0] exp, input string tag);
    int lat;
    lat = 0;
    while (ack_a == '0 && lat < 40) begin
      tick();
      lat++;
    end
    chk(tag, 32'(ack_a), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR-1:0] any_ack;
    rst     = 1'b1;
    req_a   = '0; req_b = '0; req_c = '0;
    bound_a = '0; bound_b = '0; bound_c = '0;
    tick(); tick(); tick();
    chk("rst.ack", 32'(ack_a), 32'd0);
    chk("rst.rand", 32'(rand_a), 32'd0);
    chk("rst.busy", 32'(busy_a), 32'd0);
    chk("rst.gen_b", 32'(u_b.u_lfsr.g_q), 32'd3);
    rst = 1'b0;
    tick();

    // Full range: seed 1 steps to 2.
    txn(0, 0, 10'd0, 4, 10'd2, 1'b1, "t1");
    chk("t1.gen", 32'(u_a.u_lfsr.g_q), 32'd2);

    // Generator 4 then 8, both masked by 7.
    txn(0, 0, 10'd5, 4, 10'd4, 1'b1, "t2a");
    txn(0, 0, 10'd5, 4, 10'd0, 1'b1, "t2b");

    // Seed 3: 6 rejected, then 12&7=4 accepted.
    txn(1, 0, 10'd5, 6, 10'd4, 1'b1, "t3");
    // Seed 3, one try: 6 rejected, fallback 6-5=1.
    txn(2, 0, 10'd5, 4, 10'd1, 1'b1, "t4");

    // Fairness from a fresh pointer.
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      expect_ack(NR'(1) << k, $sformatf("t5.rr%0d", k));
      req_a[k] = 1'b0;
      tick();
    end
    req_a = 4'b1001;
    expect_ack(4'b0001, "t5.wrap0");
    req_a[0] = 1'b0;
    tick();
    expect_ack(4'b1000, "t5.wrap3");
    req_a[3] = 1'b0;
    tick();

    // Reset while stepping aborts the transaction.
    do_reset();
    txn(0, 0, 10'd5, 4, 10'd2, 1'b1, "t6pre");
    set_bound(0, 0, 10'd5);
    req_a[0] = 1'b1;
    tick();
    tick();
    chk("t6.in_step", 32'(u_a.state_q), 32'(ST_STEP));
    rst   = 1'b1;
    req_a = '0;
    tick();
    rst = 1'b0;
    chk("t6.ack", 32'(ack_a), 32'd0);
    chk("t6.rand", 32'(rand_a), 32'd0);
    chk("t6.busy", 32'(busy_a), 32'd0);
    chk("t6.gen", 32'(u_a.u_lfsr.g_q), 32'd1);
    any_ack = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      any_ack = any_ack | ack_a;
    end
    chk("t6.no_late_ack", 32'(any_ack), 32'd0);

    txn(0, 2, 10'd1, 4, 10'd0, 1'b1, "t6.bound1");

    for (int k = 0; k < 24; k++) begin
      txn(0, int'($urandom_range(0, NR - 1)), NL'($urandom_range(1, 1023)),
          0, 10'd0, 1'b0, "soak");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
